// File: rtl/reg_access_sequencer.sv
// Register-file access sequencer: write-with-verify, read and dump-all
// commands over a valid/ready command port and a valid/ready response port.
//
// Ports:
//   clk_i, rst_i      single clock, synchronous active-high reset
//   cmd_valid_i/ready_o, cmd_op_i, cmd_reg_i, cmd_data_i   command port
//   rsp_valid_o/ready_i, rsp_data_o, rsp_reg_o, rsp_err_o, rsp_last_o
//                     response port
//   rf_we_o (active-low), rf_dst_o, rf_data_o   register-file write port
//   rf_src1_o, rf_src1_i                        register-file read port
module reg_access_sequencer #(
  parameter int DataWidth  = 16,
  parameter int SelectSize = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [SelectSize-1:0] cmd_reg_i,
  input  logic [DataWidth-1:0]  cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DataWidth-1:0]  rsp_data_o,
  output logic [SelectSize-1:0] rsp_reg_o,
  output logic                  rsp_err_o,
  output logic                  rsp_last_o,
  output logic                  rf_we_o,
  output logic [SelectSize-1:0] rf_dst_o,
  output logic [DataWidth-1:0]  rf_data_o,
  output logic [SelectSize-1:0] rf_src1_o,
  input  logic [DataWidth-1:0]  rf_src1_i
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    CHECK,
    READ,
    RESP,
    DUMP
  } state_e;

  state_e                state_q;
  logic [SelectSize-1:0] reg_q;
  logic [DataWidth-1:0]  data_q;
  logic [SelectSize-1:0] idx_q;
  logic [DataWidth-1:0]  rsp_data_q;
  logic [SelectSize-1:0] rsp_reg_q;
  logic                  rsp_err_q;
  logic                  rsp_last_q;
  logic                  rf_we_q;
  logic [SelectSize-1:0] rf_dst_q;
  logic [DataWidth-1:0]  rf_data_q;
  logic [SelectSize-1:0] rf_src1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      reg_q      <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      rsp_data_q <= '0;
      rsp_reg_q  <= '0;
      rsp_err_q  <= 1'b0;
      rsp_last_q <= 1'b0;
      rf_we_q    <= 1'b1;
      rf_dst_q   <= '0;
      rf_data_q  <= '0;
      rf_src1_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            reg_q  <= cmd_reg_i;
            data_q <= cmd_data_i;
            unique case (cmd_op_i)
              2'b00: begin
                state_q   <= WRITE;
                rf_we_q   <= 1'b0;
                rf_dst_q  <= cmd_reg_i;
                rf_src1_q <= cmd_reg_i;
                rf_data_q <= cmd_data_i;
              end
              2'b01: begin
                state_q   <= READ;
                rf_src1_q <= cmd_reg_i;
              end
              2'b10: begin
                state_q   <= DUMP;
                idx_q     <= '0;
                rf_src1_q <= '0;
              end
              default: begin
                state_q    <= RESP;
                rsp_data_q <= '0;
                rsp_reg_q  <= cmd_reg_i;
                rsp_err_q  <= 1'b1;
                rsp_last_q <= 1'b1;
              end
            endcase
          end
        end
        WRITE: begin
          state_q <= CHECK;
          rf_we_q <= 1'b1;
        end
        CHECK: begin
          state_q    <= RESP;
          rsp_data_q <= rf_src1_i;
          rsp_reg_q  <= reg_q;
          rsp_err_q  <= (rf_src1_i != data_q);
          rsp_last_q <= 1'b1;
        end
        READ: begin
          state_q    <= RESP;
          rsp_data_q <= rf_src1_i;
          rsp_reg_q  <= reg_q;
          rsp_err_q  <= 1'b0;
          rsp_last_q <= 1'b1;
        end
        DUMP: begin
          state_q    <= RESP;
          rsp_data_q <= rf_src1_i;
          rsp_reg_q  <= idx_q;
          rsp_err_q  <= 1'b0;
          rsp_last_q <= &idx_q;
        end
        RESP: begin
          if (rsp_ready_i) begin
            // Only a non-final dump response has last=0.
            if (!rsp_last_q) begin
              state_q   <= DUMP;
              idx_q     <= idx_q + 1'b1;
              rf_src1_q <= idx_q + 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_reg_o   = rsp_reg_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_last_o  = rsp_last_q;
  // Reset suppresses a write already being presented this cycle.
  assign rf_we_o     = rf_we_q | rst_i;
  assign rf_dst_o    = rf_dst_q;
  assign rf_data_o   = rf_data_q;
  assign rf_src1_o   = rf_src1_q;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Directed self-checking bench for reg_access_sequencer with a
// behavioural 8-entry register file and a read-data override.
module tb_reg_access_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_reg = 3'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_reg;
  logic        rsp_err;
  logic        rsp_last;
  logic        rf_we;
  logic [2:0]  rf_dst;
  logic [15:0] rf_data;
  logic [2:0]  rf_src1;
  logic [15:0] rf_src1_rd;

  logic [15:0] rf [8];
  logic        rf_clr = 1'b1;
  logic        frc_en = 1'b0;
  logic [2:0]  frc_reg = 3'd0;
  logic [15:0] frc_val = 16'd0;
  int          we_cnt = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_access_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_reg_i   (cmd_reg),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_reg_o   (rsp_reg),
    .rsp_err_o   (rsp_err),
    .rsp_last_o  (rsp_last),
    .rf_we_o     (rf_we),
    .rf_dst_o    (rf_dst),
    .rf_data_o   (rf_data),
    .rf_src1_o   (rf_src1),
    .rf_src1_i   (rf_src1_rd)
  );

  assign rf_src1_rd = (frc_en && rf_src1 == frc_reg) ? frc_val
                                                     : rf[rf_src1];

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
    end else if (!rf_we) begin
      rf[rf_dst] <= rf_data;
    end
    if (!rf_we) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a command at a negedge; returns at the negedge after accept.
  task automatic issue(input logic [1:0] op, input logic [2:0] r,
                       input logic [15:0] d);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_op    = op;
    cmd_reg   = r;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] r, input logic [15:0] d);
    int lat;
    issue(2'b00, r, d);
    wait_rsp(lat);
    consume();
  endtask

  initial begin
    int lat;
    int w0;
    int n;
    int cyc;
    logic [15:0] exp_d;

    @(negedge clk);
    @(negedge clk);
    check("rst_we", {31'd0, rf_we}, 1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    rst = 1'b0;
    rf_clr = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 1);
    check("rst_outs", {rsp_data, rsp_reg, rsp_err, rsp_last, rf_dst,
                       rf_src1, 2'b00}, 0);
    check("rst_rfdata", {16'd0, rf_data}, 0);

    // Write reg 0 = 0x00A0
    w0 = we_cnt;
    issue(2'b00, 3'd0, 16'h00A0);
    check("wr_we_low", {31'd0, rf_we}, 0);
    check("wr_dst", {29'd0, rf_dst}, 0);
    check("wr_data", {16'd0, rf_data}, 32'h00A0);
    wait_rsp(lat);
    check("wr_lat", lat, 2);
    check("wr_rsp_data", {16'd0, rsp_data}, 32'h00A0);
    check("wr_rsp_reg", {29'd0, rsp_reg}, 0);
    check("wr_rsp_err", {31'd0, rsp_err}, 0);
    check("wr_rsp_last", {31'd0, rsp_last}, 1);
    check("wr_ready_low", {31'd0, cmd_ready}, 0);
    consume();
    check("wr_one_we", we_cnt - w0, 1);

    // Write reg 1, then read reg 0; a stray command during RESP is ignored
    do_write(3'd1, 16'h000A);
    w0 = we_cnt;
    issue(2'b01, 3'd0, 16'h0000);
    wait_rsp(lat);
    check("rd_lat", lat, 1);
    cmd_op = 2'b00;
    cmd_reg = 3'd2;
    cmd_data = 16'hFFFF;
    cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rd_hold_valid", {31'd0, rsp_valid}, 1);
    check("rd_rsp_data", {16'd0, rsp_data}, 32'h00A0);
    check("rd_rsp_reg", {29'd0, rsp_reg}, 0);
    check("rd_rsp_err", {31'd0, rsp_err}, 0);
    check("rd_rsp_last", {31'd0, rsp_last}, 1);
    cmd_valid = 1'b0;
    consume();
    check("rd_idle", {30'd0, cmd_ready, rsp_valid}, 2);
    check("rd_no_write", we_cnt - w0, 0);
    check("rd_reg2", {16'd0, rf[2]}, 0);
    check("rd_reg1", {16'd0, rf[1]}, 32'h000A);

    // Write-verify mismatch on reg 3
    frc_en = 1'b1;
    frc_reg = 3'd3;
    frc_val = 16'h1235;
    issue(2'b00, 3'd3, 16'h1234);
    wait_rsp(lat);
    check("vf_rsp_err", {31'd0, rsp_err}, 1);
    check("vf_rsp_data", {16'd0, rsp_data}, 32'h1235);
    check("vf_rsp_reg", {29'd0, rsp_reg}, 3);
    consume();
    frc_en = 1'b0;

    // Load regs and dump with toggling rsp_ready
    for (int k = 0; k < 8; k++) do_write(k[2:0], 16'h0100 + k[15:0]);
    issue(2'b10, 3'd0, 16'h0000);
    wait_rsp(lat);
    check("dp_lat", lat, 1);
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 200) begin
      rsp_ready = ~rsp_ready;
      if (rsp_valid) begin
        exp_d = 16'h0100 + n[15:0];
        check("dp_data", {16'd0, rsp_data}, {16'd0, exp_d});
        check("dp_reg", {29'd0, rsp_reg}, n);
        check("dp_err", {31'd0, rsp_err}, 0);
        check("dp_last", {31'd0, rsp_last}, (n == 7) ? 1 : 0);
        if (rsp_ready) n++;
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    check("dp_count", n, 8);
    check("dp_idle", {30'd0, cmd_ready, rsp_valid}, 2);

    // Reserved op
    w0 = we_cnt;
    issue(2'b11, 3'd4, 16'hBEEF);
    wait_rsp(lat);
    check("rs_lat", lat, 0);
    check("rs_rsp_err", {31'd0, rsp_err}, 1);
    check("rs_rsp_last", {31'd0, rsp_last}, 1);
    check("rs_rsp_data", {16'd0, rsp_data}, 0);
    consume();
    check("rs_no_write", we_cnt - w0, 0);
    check("rs_idle", {30'd0, cmd_ready, rsp_valid}, 2);

    // Reset during the WRITE cycle of reg 5
    w0 = we_cnt;
    issue(2'b00, 3'd5, 16'hDEAD);
    check("ab_we_pre", {31'd0, rf_we}, 0);
    rst = 1'b1;
    #1;
    check("ab_we_rst", {31'd0, rf_we}, 1);
    @(negedge clk);
    rst = 1'b0;
    check("ab_no_write", we_cnt - w0, 0);
    check("ab_reg5", {16'd0, rf[5]}, 32'h0105);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("ab_no_rsp", n, 0);
    check("ab_ready", {31'd0, cmd_ready}, 1);
    check("ab_reg5_end", {16'd0, rf[5]}, 32'h0105);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_access_sequencer.md
REG_ACCESS_SEQUENCER -- requirements
Module: reg_access_sequencer

Interface
REQ-001 SHALL have parameter DataWidth, default 16, register data width.
REQ-002 SHALL have parameter SelectSize, default 3, register select width (8 registers).
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid_i  in  1  command request.
REQ-006 cmd_ready_o  out  1  sequencer can accept a command.
REQ-007 cmd_op_i  in  2  00 write, 01 read, 10 dump-all, 11 reserved.
REQ-008 cmd_reg_i  in  SelectSize  target register.
REQ-009 cmd_data_i  in  DataWidth  write data.
REQ-010 rsp_valid_o  out  1  response available.
REQ-011 rsp_ready_i  in  1  response consumed.
REQ-012 rsp_data_o  out  DataWidth  read/readback data.
REQ-013 rsp_reg_o  out  SelectSize  register the response refers to.
REQ-014 rsp_err_o  out  1  write-verify mismatch or reserved op.
REQ-015 rsp_last_o  out  1  final response of a command.
REQ-016 rf_we_o  out  1  register-file write enable, active-low (0 = write).
REQ-017 rf_dst_o  out  SelectSize  register-file destination select.
REQ-018 rf_data_o  out  DataWidth  register-file write data.
REQ-019 rf_src1_o  out  SelectSize  register-file read select.
REQ-020 rf_src1_i  in  DataWidth  register-file read data (combinational from rf_src1_o).

Function
REQ-021 States SHALL be IDLE, WRITE, CHECK, READ, RESP, DUMP.
REQ-022 cmd_ready_o SHALL be 1 only in IDLE; command accepted on edge with cmd_valid_i && cmd_ready_o; cmd_reg_i/cmd_data_i captured then.
REQ-023 Write: IDLE -> WRITE (1 cycle; rf_we_o=0, rf_dst_o=rf_src1_o=reg, rf_data_o=data) -> CHECK (1 cycle; rf_we_o=1, sample rf_src1_i) -> RESP.
REQ-024 In RESP after a write: rsp_data_o=sampled readback, rsp_err_o=(readback != written data), rsp_last_o=1.
REQ-025 Read: IDLE -> READ (1 cycle; rf_src1_o=reg, sample rf_src1_i) -> RESP with rsp_err_o=0, rsp_last_o=1.
REQ-026 Dump: IDLE -> DUMP with index 0; each DUMP cycle samples register [index] -> RESP; on handshake in RESP, index<7 -> index+1 and back to DUMP, index=7 -> IDLE.
REQ-027 Dump responses SHALL carry rsp_reg_o=index, rsp_err_o=0, rsp_last_o=1 only for index 7; index SHALL not wrap.
REQ-028 Reserved op 11: IDLE -> RESP directly, rsp_err_o=1, rsp_last_o=1, rsp_data_o=0, no register-file write.
REQ-029 rsp_valid_o SHALL be 1 only in RESP; rsp_* outputs SHALL hold stable until rsp_ready_i sampled high; RESP -> IDLE (or DUMP) on that edge.
REQ-030 rf_we_o SHALL be 0 only in WRITE and only while rst_i=0; exactly one write cycle per write command.
REQ-031 cmd_valid_i outside IDLE SHALL be ignored (no queuing); new command accepted no earlier than the cycle after RESP handshake.
REQ-032 Minimum latency accept->rsp_valid_o: write 2 cycles, read 1 cycle, dump first response 1 cycle.

Reset
REQ-033 On rising edge with rst_i=1: state IDLE, dump index 0, captured registers 0.
REQ-034 Reset values: cmd_ready_o=1 (after reset released), rsp_valid_o=0, rsp_data_o=0, rsp_reg_o=0, rsp_err_o=0, rsp_last_o=0, rf_we_o=1, rf_dst_o=0, rf_src1_o=0, rf_data_o=0.
REQ-035 Reset mid-operation (including during WRITE) SHALL abort without performing a register write and drop any pending response.

Verification
REQ-036 Write reg 0 = 0x00A0, rsp_ready_i=1 -> one rf_we_o=0 cycle, response rsp_data_o=0x00A0, rsp_reg_o=0, rsp_err_o=0, rsp_last_o=1.
REQ-037 Write reg 1 = 0x000A then read reg 0 -> read response rsp_data_o=0x00A0, rsp_reg_o=0.
REQ-038 Write reg 3 = 0x1234 with register-file model forcing read data 0x1235 -> rsp_err_o=1, rsp_data_o=0x1235.
REQ-039 Regs k loaded with 0x0100+k, dump with rsp_ready_i toggling every other cycle -> 8 responses in order 0..7, data 0x0100..0x0107, rsp_last_o only on reg 7, outputs stable while stalled.
REQ-040 Reserved op 11 -> single response rsp_err_o=1, rf_we_o stays 1 throughout.
REQ-041 Assert rst_i during WRITE cycle of a write to reg 5 -> rf_we_o=1 that cycle, reg 5 unchanged, no response, cmd_ready_o=1 after release.
